// File: rtl/fpu_ctrl_pkg.sv
// fpu_ctrl_pkg: shared types for the shared FPU arbiter and its tag pipeline
package fpu_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;
    typedef logic req_id_t;
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;
endpackage

// File: rtl/fpu_tag_pipe.sv
// fpu_tag_pipe: LATENCY-deep shift of issue tags aligned with the datapath result
module fpu_tag_pipe
    import fpu_ctrl_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  tag_t i_tag,
    output tag_t o_tag
);
    tag_t stage [LATENCY];
    // shift tags one stage per cycle; reset discards everything in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= i_tag;
            for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
    end
    assign o_tag = stage[LATENCY-1];
endmodule

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: round-robin sharing of one fixed-latency FPU add/sub between two requesters
module fpu_share_arbiter
    import fpu_ctrl_pkg::*;
#(
    parameter int NUM_OP     = 1,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [1:0]                    i_req_valid,
    output logic [1:0]                    o_req_ready,
    input  logic [2*DATA_WIDTH-1:0]       i_req_a,
    input  logic [2*DATA_WIDTH-1:0]       i_req_b,
    input  logic [2*NUM_OP-1:0]           i_req_op,
    output logic                          o_fpu_valid,
    output logic [DATA_WIDTH-1:0]         o_fpu_a,
    output logic [DATA_WIDTH-1:0]         o_fpu_b,
    output logic [NUM_OP-1:0]             o_fpu_op,
    input  logic [DATA_WIDTH-1:0]         i_fpu_result,
    input  logic                          i_fpu_overflow,
    output logic [1:0]                    o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_result,
    output logic                          o_rsp_overflow,
    input  logic                          i_drain,
    output logic                          o_idle,
    output logic [$clog2(LATENCY+3)-1:0]  o_inflight
);
    localparam int IW = $clog2(LATENCY+3);
    state_t  state;
    req_id_t rr_ptr;
    req_id_t win;
    req_id_t fpu_id;
    logic [1:0] grant;
    logic hs;
    tag_t tag_in;
    tag_t tag_out;
    // pick the winner: rr_ptr under contention, otherwise the single valid requester
    always_comb begin
        win   = &i_req_valid ? rr_ptr : i_req_valid[1];
        grant = (state == RUN && !i_drain) ? (i_req_valid & (win ? 2'b10 : 2'b01)) : 2'b00;
        hs    = |grant;
    end
    assign o_req_ready = grant;
    assign o_idle      = state == HALT;
    assign tag_in      = {o_fpu_valid, fpu_id};
    // register the granted operation towards the datapath; operands hold when idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fpu_valid <= 1'b0;
            o_fpu_a     <= '0;
            o_fpu_b     <= '0;
            o_fpu_op    <= '0;
            fpu_id      <= '0;
        end else begin
            o_fpu_valid <= hs;
            if (hs) begin
                o_fpu_a  <= win ? i_req_a[2*DATA_WIDTH-1:DATA_WIDTH] : i_req_a[DATA_WIDTH-1:0];
                o_fpu_b  <= win ? i_req_b[2*DATA_WIDTH-1:DATA_WIDTH] : i_req_b[DATA_WIDTH-1:0];
                o_fpu_op <= win ? i_req_op[2*NUM_OP-1:NUM_OP] : i_req_op[NUM_OP-1:0];
                fpu_id   <= win;
            end
        end
    end
    // hand priority to the loser after every contested grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rr_ptr <= '0;
        else if (hs && &i_req_valid) rr_ptr <= ~win;
    end
    // run / drain / halt sequencing
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= RUN;
        else state <= (state == RUN && i_drain) ? DRAIN :
                      (state == DRAIN && o_inflight == '0) ? HALT :
                      (state == HALT && !i_drain) ? RUN : state;
    end
    // count operations between handshake and response
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_inflight <= '0;
        else o_inflight <= o_inflight + IW'(hs) - IW'(|o_rsp_valid);
    end
    fpu_tag_pipe #(.LATENCY(LATENCY)) u_tag_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_tag   (tag_in),
        .o_tag   (tag_out)
    );
    // route the datapath result to the requester recorded in the tag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rsp_valid    <= 2'b00;
            o_rsp_result   <= '0;
            o_rsp_overflow <= 1'b0;
        end else begin
            o_rsp_valid <= tag_out.valid ? (tag_out.id ? 2'b10 : 2'b01) : 2'b00;
            if (tag_out.valid) begin
                o_rsp_result   <= i_fpu_result;
                o_rsp_overflow <= i_fpu_overflow;
            end
        end
    end
endmodule

// File: tb/tb_fpu_share_arbiter.sv
// tb_fpu_share_arbiter: directed checks of arbitration, routing, drain and reset
module tb_fpu_share_arbiter;
    localparam int L  = 3;
    localparam int DW = 32;
    localparam int IW = $clog2(L+3);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic drain = 1'b0;
    logic [1:0] req_valid = 2'b00;
    logic [2*DW-1:0] req_a = '0;
    logic [2*DW-1:0] req_b = '0;
    logic [1:0] req_op = 2'b00;
    logic [1:0] req_ready;
    logic fpu_valid;
    logic [DW-1:0] fpu_a, fpu_b;
    logic [0:0] fpu_op;
    logic [DW-1:0] fpu_result;
    logic fpu_overflow;
    logic [1:0] rsp_valid;
    logic [DW-1:0] rsp_result;
    logic rsp_overflow;
    logic idle;
    logic [IW-1:0] inflight;
    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_r [L];
    logic          m_o [L];

    fpu_share_arbiter #(.NUM_OP(1), .DATA_WIDTH(DW), .LATENCY(L)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_op(req_op),
        .o_fpu_valid(fpu_valid), .o_fpu_a(fpu_a), .o_fpu_b(fpu_b), .o_fpu_op(fpu_op),
        .i_fpu_result(fpu_result), .i_fpu_overflow(fpu_overflow),
        .o_rsp_valid(rsp_valid), .o_rsp_result(rsp_result), .o_rsp_overflow(rsp_overflow),
        .i_drain(drain), .o_idle(idle), .o_inflight(inflight)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fres(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op);
        if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (!op && a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return 32'h7F800000;
        return op ? a - b : a + b;
    endfunction

    // behavioural datapath: result appears L cycles after o_fpu_valid
    always @(posedge clk) begin
        m_r[0] <= fpu_valid ? fres(fpu_a, fpu_b, fpu_op[0]) : '0;
        m_o[0] <= fpu_valid && !fpu_op[0] && fpu_a == 32'h7F7FFFFF && fpu_b == 32'h7F7FFFFF;
        for (int i = 1; i < L; i++) begin
            m_r[i] <= m_r[i-1];
            m_o[i] <= m_o[i-1];
        end
    end
    assign fpu_result   = m_r[L-1];
    assign fpu_overflow = m_o[L-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        drain = 1'b0;
        req_a = '0;
        req_b = '0;
        req_op = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, fpu_valid, rsp_valid, rsp_overflow, idle, inflight} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b fv=%b rv=%b ov=%b idle=%b inf=%0d exp all 0", req_ready, fpu_valid, rsp_valid, rsp_overflow, idle, inflight);
        end
        checks++;
        if ({fpu_a, fpu_b, rsp_result} !== '0) begin
            errors++;
            $display("FAIL reset_data got a=%h b=%h res=%h exp 0", fpu_a, fpu_b, rsp_result);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_valid = 2'b01;
        req_a = {32'h0, 32'h3F800000};
        req_b = {32'h0, 32'h40000000};
        req_op = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b exp 01", req_ready); end
        tick();
        req_valid = 2'b00;
        checks++;
        if ({fpu_valid, fpu_a, fpu_b} !== {1'b1, 32'h3F800000, 32'h40000000}) begin
            errors++;
            $display("FAIL single_issue got v=%b a=%h b=%h exp 1 3f800000 40000000", fpu_valid, fpu_a, fpu_b);
        end
        repeat (3) tick();
        checks++;
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_early got %b exp 00", rsp_valid); end
        tick();
        checks++;
        if ({rsp_valid, rsp_result, rsp_overflow} !== {2'b01, 32'h40400000, 1'b0}) begin
            errors++;
            $display("FAIL single_rsp got v=%b r=%h o=%b exp 01 40400000 0", rsp_valid, rsp_result, rsp_overflow);
        end
        tick();
        checks++;
        if ({rsp_valid, inflight} !== '0) begin
            errors++;
            $display("FAIL single_after got v=%b inf=%0d exp 00 0", rsp_valid, inflight);
        end
    endtask

    task automatic test_contention();
        logic [1:0] seen [$];
        logic [31:0] res [$];
        int peak = 0;
        for (int c = 0; c < 16; c++) begin
            if (c < 6) begin
                req_valid = 2'b11;
                req_a = {32'(32'h200 + c), 32'(32'h100 + c)};
                req_b = '0;
            end else req_valid = 2'b00;
            #1;
            if (c < 6) begin
                checks++;
                if (req_ready !== ((c % 2) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL cont_grant[%0d] got %b exp %b", c, req_ready, (c % 2) ? 2'b10 : 2'b01);
                end
            end
            checks++;
            if (rsp_valid === 2'b11) begin errors++; $display("FAIL cont_onehot got 11 exp one-hot"); end
            if (rsp_valid !== 2'b00) begin
                seen.push_back(rsp_valid);
                res.push_back(rsp_result);
            end
            if (int'(inflight) > peak) peak = int'(inflight);
            tick();
        end
        checks++;
        if (seen.size() != 6) begin
            errors++;
            $display("FAIL cont_count got %0d exp 6", seen.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if ({seen[k], res[k]} !== {(k % 2) ? 2'b10 : 2'b01, 32'((k % 2) ? 32'h200 + k : 32'h100 + k)}) begin
                    errors++;
                    $display("FAIL cont_rsp[%0d] got v=%b r=%h exp v=%b r=%h", k, seen[k], res[k], (k % 2) ? 2'b10 : 2'b01, 32'((k % 2) ? 32'h200 + k : 32'h100 + k));
                end
            end
        end
        checks++;
        if (peak != 5) begin errors++; $display("FAIL cont_peak got %0d exp 5", peak); end
    endtask

    task automatic test_uncontested();
        for (int c = 0; c < 3; c++) begin
            req_valid = 2'b10;
            #1;
            checks++;
            if (req_ready !== 2'b10) begin errors++; $display("FAIL unc_grant[%0d] got %b exp 10", c, req_ready); end
            tick();
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL unc_first_contest got %b exp 01", req_ready); end
        tick();
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL unc_second_contest got %b exp 10", req_ready); end
        tick();
        req_valid = 2'b00;
        repeat (8) tick();
        checks++;
        if (inflight !== '0) begin errors++; $display("FAIL unc_inflight got %0d exp 0", inflight); end
    endtask

    task automatic test_drain();
        int n = 0;
        int nrsp = 0;
        for (int c = 0; c < 3; c++) begin
            req_valid = 2'b01;
            #1;
            tick();
        end
        drain = 1'b1;
        #1;
        checks++;
        if ({req_ready, inflight} !== {2'b00, IW'(3)}) begin
            errors++;
            $display("FAIL drain_start got rdy=%b inf=%0d exp 00 3", req_ready, inflight);
        end
        while (!idle && n < 12) begin
            tick();
            n++;
            if (rsp_valid !== 2'b00) nrsp++;
        end
        checks++;
        if (!idle || n > L + 3) begin errors++; $display("FAIL drain_halt got idle=%b after %0d cycles exp 1 within %0d", idle, n, L + 3); end
        checks++;
        if (nrsp != 3 || inflight !== '0) begin
            errors++;
            $display("FAIL drain_rsp got rsp=%0d inf=%0d exp 3 0", nrsp, inflight);
        end
        tick();
        checks++;
        if ({req_ready, idle} !== 3'b001) begin errors++; $display("FAIL halt_hold got rdy=%b idle=%b exp 00 1", req_ready, idle); end
        drain = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin errors++; $display("FAIL halt_release got %b exp 00", req_ready); end
        tick();
        checks++;
        if ({req_ready, idle} !== 3'b010) begin errors++; $display("FAIL regrant got rdy=%b idle=%b exp 01 0", req_ready, idle); end
        tick();
        req_valid = 2'b00;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        logic any_rsp = 1'b0;
        req_valid = 2'b01;
        #1;
        tick();
        tick();
        req_valid = 2'b00;
        tick();
        checks++;
        if (inflight !== IW'(2)) begin errors++; $display("FAIL rmid_inflight got %0d exp 2", inflight); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, fpu_valid, rsp_valid, idle, inflight} !== '0) begin
            errors++;
            $display("FAIL rmid_outputs got rdy=%b fv=%b rv=%b idle=%b inf=%0d exp 0", req_ready, fpu_valid, rsp_valid, idle, inflight);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (rsp_valid !== 2'b00) any_rsp = 1'b1;
        end
        checks++;
        if (any_rsp || inflight !== '0) begin
            errors++;
            $display("FAIL rmid_ghost got rsp_seen=%b inf=%0d exp 0 0", any_rsp, inflight);
        end
    endtask

    task automatic test_overflow();
        req_valid = 2'b10;
        req_a = {32'h7F7FFFFF, 32'h0};
        req_b = {32'h7F7FFFFF, 32'h0};
        req_op = 2'b00;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin errors++; $display("FAIL ovf_grant1 got %b exp 10", req_ready); end
        tick();
        req_valid = 2'b01;
        req_a = {32'h0, 32'h3F800000};
        req_b = {32'h0, 32'h40000000};
        #1;
        tick();
        req_valid = 2'b00;
        repeat (3) tick();
        checks++;
        if ({rsp_valid, rsp_result, rsp_overflow} !== {2'b10, 32'h7F800000, 1'b1}) begin
            errors++;
            $display("FAIL ovf_rsp1 got v=%b r=%h o=%b exp 10 7f800000 1", rsp_valid, rsp_result, rsp_overflow);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_result, rsp_overflow} !== {2'b01, 32'h40400000, 1'b0}) begin
            errors++;
            $display("FAIL ovf_rsp0 got v=%b r=%h o=%b exp 01 40400000 0", rsp_valid, rsp_result, rsp_overflow);
        end
        tick();
        checks++;
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL ovf_after got %b exp 00", rsp_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset();
        test_contention();
        test_reset();
        test_uncontested();
        test_reset();
        test_drain();
        test_reset();
        test_reset_mid();
        test_reset();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/fpu_share_arbiter.md
# fpu_share_arbiter

Shares one fixed-latency floating-point add/sub datapath (exponent compare, mantissa align/add, normalize) between two requesters. Round-robin arbitration issues at most one operation per cycle. A tag pipeline matched to the datapath latency routes each result back to the requester that issued it. A drain FSM quiesces the datapath for reconfiguration or power-down.

## Interface
- NUM_OP, 1, width of the add/sub opcode passed through to the datapath
- DATA_WIDTH, 32, IEEE-754 operand/result width
- LATENCY, 3, fixed datapath latency in cycles from o_fpu_valid to i_fpu_result (legal ≥1)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock, reset asynchronous and active-low
- i_req_valid  in  2  per-requester request valid (bit i = requester i)
- o_req_ready  out  2  per-requester accept
- i_req_a  in  2*DATA_WIDTH  operand A, requester i at slice [i*DATA_WIDTH +: DATA_WIDTH]
- i_req_b  in  2*DATA_WIDTH  operand B, same packing
- i_req_op  in  2*NUM_OP  add/sub opcode, same packing
- o_fpu_valid  out  1  operation issued to datapath this cycle
- o_fpu_a, o_fpu_b  out  DATA_WIDTH  issued operands
- o_fpu_op  out  NUM_OP  issued opcode
- i_fpu_result  in  DATA_WIDTH  datapath result, valid exactly LATENCY cycles after o_fpu_valid
- i_fpu_overflow  in  1  datapath overflow flag, same timing
- o_rsp_valid  out  2  one-hot response valid; no back-pressure
- o_rsp_result  out  DATA_WIDTH  response result (shared by both requesters)
- o_rsp_overflow  out  1  response overflow
- i_drain  in  1  quiesce request (level)
- o_idle  out  1  high in HALT state
- o_inflight  out  $clog2(LATENCY+3)  operations issued but not yet responded

## Operation
- Grant: only in RUN with i_drain=0. Single valid wins. Both valid: requester selected by rr_ptr wins. Ready may depend on valid; valid must not depend on ready.
- o_req_ready[i] = grant[i]. Handshake = valid & ready.
- rr_ptr (reset 0) moves to the non-granted requester after any contested grant. It is unchanged on an uncontested grant or with no grant.
- Issue: on handshake, operands, opcode and requester id are registered. o_fpu_valid is high the following cycle, otherwise 0. Operands hold their last value when not valid.
- Tag pipe: LATENCY-deep shift of {valid, id}, entered when o_fpu_valid is high. The output stage aligns with i_fpu_result.
- Response: registered. o_rsp_valid[id]=1 for one cycle with the captured result/overflow. o_rsp_valid is never 2'b11.
- o_inflight: +1 on handshake, −1 on o_rsp_valid; both in the same cycle leaves it unchanged. Max LATENCY+2.
- FSM:
  - RUN: i_drain=1 → DRAIN. Ready is already 0 in the cycle i_drain rises.
  - DRAIN: no grants. When o_inflight==0 → HALT.
  - HALT: o_idle=1. When i_drain=0 → RUN. Grants resume the cycle after entering RUN.
- Reset (async, any time): state RUN, rr_ptr 0, tag pipe cleared, all outputs 0. In-flight operations are discarded and produce no response.

## Timing
- Handshake at cycle t → o_fpu_valid at t+1 → i_fpu_result sampled at t+1+LATENCY → o_rsp_valid at t+2+LATENCY. Total latency LATENCY+2.
- Throughput: one operation per cycle, sustained. Back-to-back alternating grants under continuous contention.
- Responses return in issue order.
- Drain from RUN with N in flight reaches HALT in at most LATENCY+3 cycles.

## Structure
- Package fpu_ctrl_pkg:
  - state enum {RUN, DRAIN, HALT}
  - req_id_t (1 bit)
  - tag struct {valid, id}
- Sub-module fpu_tag_pipe: parameterised LATENCY shift register of tags with async active-low clear.
- Arbiter, issue registers, response registers, inflight counter and FSM live in fpu_share_arbiter.
- The bench drives the datapath side with a LATENCY-cycle behavioural model.

## Test plan
- Single request: req0 with A=0x3F800000, B=0x40000000, add. Ready the same cycle. o_fpu_valid 1 cycle later. o_rsp_valid=2'b01 with 0x40400000 at handshake+5 (LATENCY=3).
- Contention: both valid for 6 cycles after reset. Grants go 0,1,0,1,0,1. Responses alternate 01,10,… in the same order. o_inflight peaks at 5.
- Uncontested: req1 alone for 3 cycles, then both valid. First contested grant goes to 0 (rr_ptr still 0).
- Drain mid-stream: i_drain asserted with 3 in flight. Ready 0 the same cycle. 3 responses still arrive. o_idle rises when o_inflight hits 0. Dropping i_drain re-grants after one cycle.
- Reset mid-operation: i_rst_n low 2 cycles after issuing 2 ops. All outputs 0 immediately. No o_rsp_valid after release. o_inflight=0.
- Overflow pass-through: model returns i_fpu_overflow=1 for requester 1's op. o_rsp_valid=2'b10 with o_rsp_overflow=1 for that response only.
